// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the logic unit and its two-port arbiter:
//   - logic unit opcode encodings
//   - requester id width and type
//   - default result for the unknown opcode
//   - result-slot state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [1:0] LU_AND = 2'b00;
   localparam logic [1:0] LU_OR  = 2'b01;
   localparam logic [1:0] LU_XOR = 2'b10;
   localparam logic [1:0] LU_UNK = 2'b11;

   localparam int unsigned REQ_ID_W = 1;
   typedef logic [REQ_ID_W-1:0] req_id_t;

   localparam logic [31:0] LU_UNKNOWN_RESULT_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter_if
// Request/response bundle between two requesters and logic_unit_arbiter.
//   req0_* / req1_* : request channels (valid/ready, operands, opcode)
//   rsp0_* / rsp1_* : response channels (valid/ready)
//   rsp_result_o / rsp_err_o : result slot shared by both response channels
// Modports:
//   master : requester side (drives requests and response readies)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface logic_unit_arbiter_if;

   logic        req0_valid_i;
   logic        req0_ready_o;
   logic [31:0] req0_op_a_i;
   logic [31:0] req0_op_b_i;
   logic [1:0]  req0_opcode_i;

   logic        req1_valid_i;
   logic        req1_ready_o;
   logic [31:0] req1_op_a_i;
   logic [31:0] req1_op_b_i;
   logic [1:0]  req1_opcode_i;

   logic        rsp0_valid_o;
   logic        rsp0_ready_i;
   logic        rsp1_valid_o;
   logic        rsp1_ready_i;
   logic [31:0] rsp_result_o;
   logic        rsp_err_o;

   modport master (
      output req0_valid_i, req0_op_a_i, req0_op_b_i, req0_opcode_i,
      output req1_valid_i, req1_op_a_i, req1_op_b_i, req1_opcode_i,
      output rsp0_ready_i, rsp1_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_err_o
   );

   modport slave (
      input  req0_valid_i, req0_op_a_i, req0_op_b_i, req0_opcode_i,
      input  req1_valid_i, req1_op_a_i, req1_op_b_i, req1_opcode_i,
      input  rsp0_ready_i, rsp1_ready_i,
      output req0_ready_o, req1_ready_o,
      output rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_err_o
   );

endinterface

// File: rtl/logic_unit.sv
// ---------------------------------------------------------------------------
// logic_unit
// Purely combinational bitwise unit.
//   op_a_i, op_b_i : 32-bit operands
//   opcode_i       : 00 AND, 01 OR, 10 XOR, 11 unknown
//   result_o       : result; UNKNOWN_OPCODE_RESULT for opcode 11
// ---------------------------------------------------------------------------
module logic_unit
   import alu_pkg::*;
#(
   parameter logic [31:0] UNKNOWN_OPCODE_RESULT = LU_UNKNOWN_RESULT_DEFAULT
) (
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [1:0]  opcode_i,
   output logic [31:0] result_o
);

   always_comb begin
      result_o = UNKNOWN_OPCODE_RESULT;
      case (opcode_i)
         LU_AND:  result_o = op_a_i & op_b_i;
         LU_OR:   result_o = op_a_i | op_b_i;
         LU_XOR:  result_o = op_a_i ^ op_b_i;
         default: result_o = UNKNOWN_OPCODE_RESULT;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// Shares one logic_unit between two requesters with round-robin arbitration.
// The winner's result is registered into a single output slot and returned on
// that requester's response channel until it is accepted.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : request/response bundle (slave side)
// Parameters:
//   UNKNOWN_OPCODE_RESULT : result for opcode 11, forwarded to logic_unit
//   INIT_PRIO             : requester holding priority after reset
// ---------------------------------------------------------------------------
module logic_unit_arbiter
   import alu_pkg::*;
#(
   parameter logic [31:0] UNKNOWN_OPCODE_RESULT = LU_UNKNOWN_RESULT_DEFAULT,
   parameter logic        INIT_PRIO             = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   logic_unit_arbiter_if.slave   bus
);

   slot_state_e state_q, state_d;
   req_id_t     owner_q, owner_d;
   req_id_t     prio_q, prio_d;
   logic        err_q, err_d;
   logic [31:0] result_q, result_d;

   logic        drain;
   logic        can_accept;
   logic        grant_vld;
   req_id_t     grant_id;
   logic [31:0] lu_op_a;
   logic [31:0] lu_op_b;
   logic [1:0]  lu_opcode;
   logic [31:0] lu_result;

   // Arbitration: the slot can take a new result when empty, or when the
   // current owner is taking its result this very cycle (back-to-back).
   always_comb begin
      drain = 1'b0;
      if (state_q == SLOT_FULL) begin
         drain = (owner_q == 1'b0) ? bus.rsp0_ready_i : bus.rsp1_ready_i;
      end
      can_accept = (state_q == SLOT_EMPTY) | drain;

      grant_id = prio_q;
      if (bus.req0_valid_i && bus.req1_valid_i) begin
         grant_id = prio_q;
      end else if (bus.req0_valid_i) begin
         grant_id = 1'b0;
      end else if (bus.req1_valid_i) begin
         grant_id = 1'b1;
      end

      // Reset suppresses the handshake so nothing is captured in that cycle.
      grant_vld = can_accept & (bus.req0_valid_i | bus.req1_valid_i) & ~rst_i;

      bus.req0_ready_o = grant_vld & (grant_id == 1'b0);
      bus.req1_ready_o = grant_vld & (grant_id == 1'b1);

      lu_op_a   = (grant_id == 1'b1) ? bus.req1_op_a_i   : bus.req0_op_a_i;
      lu_op_b   = (grant_id == 1'b1) ? bus.req1_op_b_i   : bus.req0_op_b_i;
      lu_opcode = (grant_id == 1'b1) ? bus.req1_opcode_i : bus.req0_opcode_i;
   end

   logic_unit #(
      .UNKNOWN_OPCODE_RESULT (UNKNOWN_OPCODE_RESULT)
   ) u_logic_unit (
      .op_a_i   (lu_op_a),
      .op_b_i   (lu_op_b),
      .opcode_i (lu_opcode),
      .result_o (lu_result)
   );

   // Next-state logic for the slot. An accept wins over a plain drain, which
   // keeps the slot FULL with the new data when both happen together.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      err_d    = err_q;
      result_d = result_q;
      if (grant_vld) begin
         state_d  = SLOT_FULL;
         owner_d  = grant_id;
         err_d    = (lu_opcode == LU_UNK);
         result_d = lu_result;
         prio_d   = ~grant_id;
      end else if (drain) begin
         state_d = SLOT_EMPTY;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= SLOT_EMPTY;
         owner_q  <= 1'b0;
         prio_q   <= INIT_PRIO;
         err_q    <= 1'b0;
         result_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   // Response outputs
   always_comb begin
      bus.rsp0_valid_o = (state_q == SLOT_FULL) & (owner_q == 1'b0);
      bus.rsp1_valid_o = (state_q == SLOT_FULL) & (owner_q == 1'b1);
      bus.rsp_result_o = result_q;
      bus.rsp_err_o    = err_q;
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

   typedef struct packed {
      logic        rst;
      logic        v0;
      logic [1:0]  op0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic        v1;
      logic [1:0]  op1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic        r0;
      logic        r1;
      logic        e_rdy0;
      logic        e_rdy1;
      logic        e_rv0;
      logic        e_rv1;
      logic        chk;
      logic [31:0] e_res;
      logic        e_err;
   } vec_t;

   localparam int NVEC = 17;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   vec_t tbl [NVEC];

   logic_unit_arbiter_if bus ();

   logic_unit_arbiter #(
      .UNKNOWN_OPCODE_RESULT (32'h0000_0000),
      .INIT_PRIO             (1'b0)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t row(
      input logic rst_, input logic v0, input logic [1:0] op0,
      input logic [31:0] a0, input logic [31:0] b0,
      input logic v1, input logic [1:0] op1,
      input logic [31:0] a1, input logic [31:0] b1,
      input logic r0, input logic r1,
      input logic e_rdy0, input logic e_rdy1, input logic e_rv0, input logic e_rv1,
      input logic chk, input logic [31:0] e_res, input logic e_err);
      vec_t v;
      v.rst = rst_; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
      v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.r0 = r0; v.r1 = r1;
      v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_rv0 = e_rv0; v.e_rv1 = e_rv1;
      v.chk = chk; v.e_res = e_res; v.e_err = e_err;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst_, input logic v0, input logic [1:0] op0,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [1:0] op1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic r0, input logic r1);
      rst = rst_;
      bus.req0_valid_i = v0; bus.req0_opcode_i = op0;
      bus.req0_op_a_i = a0;  bus.req0_op_b_i = b0;
      bus.req1_valid_i = v1; bus.req1_opcode_i = op1;
      bus.req1_op_a_i = a1;  bus.req1_op_b_i = b1;
      bus.rsp0_ready_i = r0; bus.rsp1_ready_i = r1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0);

      //            rst v0 op0    a0            b0            v1 op1    a1            b1            r0 r1 rdy0 rdy1 rv0 rv1 chk res           err
      tbl[0]  = row(1, 0, 2'b00, 32'h0,        32'h0,        0, 2'b00, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0);
      // single AND from requester 0
      tbl[1]  = row(0, 1, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 2'b00, 32'h0,      32'h0,        1, 1, 1, 0, 0, 0, 1, 32'h0000_0000, 0);
      tbl[2]  = row(0, 0, 2'b00, 32'h0,        32'h0,        0, 2'b00, 32'h0,        32'h0,        1, 0, 0, 0, 1, 0, 1, 32'h00F0_00F0, 0);
      tbl[3]  = row(1, 0, 2'b00, 32'h0,        32'h0,        0, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,         0);
      // both valid every cycle: alternating grants, one result per cycle
      tbl[4]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 1, 2'b01, 32'h1,      32'h2,        1, 1, 1, 0, 0, 0, 1, 32'h0000_0000, 0);
      tbl[5]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 1, 2'b01, 32'h1,      32'h2,        1, 1, 0, 1, 1, 0, 1, 32'hFF00_00FF, 0);
      tbl[6]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 1, 2'b01, 32'h1,      32'h2,        1, 1, 1, 0, 0, 1, 1, 32'h0000_0003, 0);
      tbl[7]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 1, 2'b01, 32'h1,      32'h2,        1, 1, 0, 1, 1, 0, 1, 32'hFF00_00FF, 0);
      // backpressure on requester 1 for three cycles, req0 waiting
      tbl[8]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 0, 2'b00, 32'h0,      32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h0000_0003, 0);
      tbl[9]  = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 0, 2'b00, 32'h0,      32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h0000_0003, 0);
      tbl[10] = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 0, 2'b00, 32'h0,      32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h0000_0003, 0);
      tbl[11] = row(0, 1, 2'b10, 32'hFFFF_0000, 32'h00FF_00FF, 0, 2'b00, 32'h0,      32'h0,        1, 1, 1, 0, 0, 1, 1, 32'h0000_0003, 0);
      // unknown opcode from requester 1, then a valid opcode clears the error
      tbl[12] = row(0, 0, 2'b00, 32'h0,        32'h0,        1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 0, 1, 1, 0, 1, 32'hFF00_00FF, 0);
      tbl[13] = row(0, 0, 2'b00, 32'h0,        32'h0,        1, 2'b01, 32'h1,        32'h2,        1, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 1);
      tbl[14] = row(0, 0, 2'b00, 32'h0,        32'h0,        1, 2'b01, 32'h1,        32'h2,        1, 1, 0, 1, 0, 1, 1, 32'h0000_0000, 1);
      tbl[15] = row(0, 0, 2'b00, 32'h0,        32'h0,        0, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 0, 1, 1, 32'h0000_0003, 0);
      tbl[16] = row(0, 0, 2'b00, 32'h0,        32'h0,        0, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0, 32'h0,         0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
               tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].r0, tbl[i].r1);
         #1;
         cmp($sformatf("row%0d req0_ready", i), 32'(bus.req0_ready_o), 32'(tbl[i].e_rdy0));
         cmp($sformatf("row%0d req1_ready", i), 32'(bus.req1_ready_o), 32'(tbl[i].e_rdy1));
         cmp($sformatf("row%0d rsp0_valid", i), 32'(bus.rsp0_valid_o), 32'(tbl[i].e_rv0));
         cmp($sformatf("row%0d rsp1_valid", i), 32'(bus.rsp1_valid_o), 32'(tbl[i].e_rv1));
         if (tbl[i].chk) begin
            cmp($sformatf("row%0d rsp_result", i), bus.rsp_result_o, tbl[i].e_res);
            cmp($sformatf("row%0d rsp_err", i), 32'(bus.rsp_err_o), 32'(tbl[i].e_err));
         end
      end

      // Reset while the slot is full and its owner is stalling.
      @(negedge clk);
      drive(0, 1, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
      #1 cmp("midrst accept req0", 32'(bus.req0_ready_o), 32'd1);
      @(negedge clk);
      drive(1, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 0);
      #1 cmp("midrst held rsp0_valid", 32'(bus.rsp0_valid_o), 32'd1);
      cmp("midrst no ready in reset", 32'(bus.req0_ready_o), 32'd0);
      @(negedge clk);
      drive(0, 1, 2'b00, 32'h0000_FFFF, 32'h00FF_00FF, 1, 2'b01, 32'h1, 32'h2, 1, 1);
      #1 cmp("midrst rsp0_valid cleared", 32'(bus.rsp0_valid_o), 32'd0);
      cmp("midrst rsp1_valid", 32'(bus.rsp1_valid_o), 32'd0);
      cmp("midrst grant req0", 32'(bus.req0_ready_o), 32'd1);
      cmp("midrst no grant req1", 32'(bus.req1_ready_o), 32'd0);

      // Requester 1 alone: four back-to-back requests, no bubbles.
      // Slot now holds req0's AND (000000FF) and rsp0_ready is high.
      begin
         logic [1:0]  ops [4];
         logic [31:0] exp_res [4];
         ops[0] = 2'b00; exp_res[0] = 32'h0000_00FF;
         ops[1] = 2'b01; exp_res[1] = 32'h00FF_FFFF;
         ops[2] = 2'b10; exp_res[2] = 32'h00FF_FF00;
         ops[3] = 2'b00; exp_res[3] = 32'h0000_00FF;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 2'b00, 32'h0, 32'h0, 1, ops[k], 32'h0000_FFFF, 32'h00FF_00FF, 1, 1);
            #1 cmp($sformatf("solo%0d req1_ready", k), 32'(bus.req1_ready_o), 32'd1);
            if (k > 0) begin
               cmp($sformatf("solo%0d rsp1_valid", k), 32'(bus.rsp1_valid_o), 32'd1);
               cmp($sformatf("solo%0d result", k), bus.rsp_result_o, exp_res[k-1]);
            end
         end
         // Pointer must be back at 0: both valid, req0 wins.
         @(negedge clk);
         drive(0, 1, 2'b01, 32'h0, 32'h0, 1, 2'b01, 32'h0, 32'h0, 1, 1);
         #1 cmp("solo last result", bus.rsp_result_o, exp_res[3]);
         cmp("solo ptr grant req0", 32'(bus.req0_ready_o), 32'd1);
         cmp("solo ptr no grant req1", 32'(bus.req1_ready_o), 32'd0);
      end

      @(negedge clk);
      drive(0, 0, 2'b00, 32'h0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 1);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one combinational logic_unit (AND/OR/XOR) between two requesters, e.g. the EX-stage ALU path (port 0) and the CSR/atomic read-modify-write path (port 1).
- Round-robin arbitration with valid/ready handshakes.
- The result is captured in a single registered output slot, returned on the granted requester's response channel, and held until that requester accepts it.

Parameters:
- UNKNOWN_OPCODE_RESULT, 32'h0, result driven for opcode 2'b11; passed through to the logic_unit instance.
- INIT_PRIO, 1'b0, requester that holds priority after reset.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req0_valid_i  in  1  requester 0 has a request
- req0_ready_o  out  1  requester 0 request accepted this cycle
- req0_op_a_i  in  32  requester 0 operand A
- req0_op_b_i  in  32  requester 0 operand B
- req0_opcode_i  in  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 unknown
- req1_valid_i  in  1  requester 1 has a request
- req1_ready_o  out  1  requester 1 request accepted this cycle
- req1_op_a_i  in  32  requester 1 operand A
- req1_op_b_i  in  32  requester 1 operand B
- req1_opcode_i  in  2  requester 1 opcode
- rsp0_valid_o  out  1  result pending for requester 0
- rsp0_ready_i  in  1  requester 0 takes its result
- rsp1_valid_o  out  1  result pending for requester 1
- rsp1_ready_i  in  1  requester 1 takes its result
- rsp_result_o  out  32  result of the slot, shared by both response channels
- rsp_err_o  out  1  slot result came from opcode 11

Behaviour:
- Reset (synchronous, rst_i high at clk_i edge):
  - slot empty; rsp0_valid_o, rsp1_valid_o, rsp_err_o = 0; rsp_result_o = 0
  - priority pointer = INIT_PRIO
  - any in-flight result is discarded; no handshake completes in the reset cycle
- Slot states:
  - EMPTY: no result held.
  - FULL: result held, with the owning requester id and the error flag.
- Drain: in FULL, drain = (owner==0 & rsp0_ready_i) | (owner==1 & rsp1_ready_i).
- can_accept = EMPTY | drain.
- Grant, combinational, valid only when can_accept:
  - Both reqN_valid_i high: grant goes to the priority pointer.
  - Only one valid: that requester is granted.
  - None valid: no grant.
- Ready: reqN_ready_o = can_accept & grant==N. It is never asserted for a requester with valid low, and never asserted for both requesters in the same cycle.
- Accept (reqN_valid_i & reqN_ready_o), capture at the next edge:
  - The muxed operands and opcode drive the logic_unit instance; its output is registered into rsp_result_o.
  - owner = N; rsp_err_o = (opcode==2'b11); slot becomes FULL.
- Priority pointer: on every accept it is set to the other requester (1-N). It is unchanged on cycles without an accept.
- Drain without accept: slot becomes EMPTY; rsp_result_o keeps its last value (don't-care).
- Drain and accept in the same cycle: slot stays FULL with the new data. This gives back-to-back throughput of one result per cycle.
- Response validity: rspN_valid_o = FULL & owner==N. Result and error flag stay stable while valid is high and ready is low.
- Latency: accept at edge k means the response is valid from edge k+1.
- Requester obligations: payload held stable while valid is high and ready is low, and valid not dropped before accept. The block does not check these.
- The response ready of the non-owner is ignored.

Decomposition:
- Shared package (alu_pkg) holds:
  - opcode constants LU_AND=2'b00, LU_OR=2'b01, LU_XOR=2'b10, LU_UNK=2'b11
  - requester id width (1)
  - the UNKNOWN_OPCODE_RESULT default
- One sub-module: an instance of the existing logic_unit, unmodified.
- Arbitration and slot FSM stay in this module; no further sub-module.

Test Plan:
- Reset, then req0 with A=32'hF0F0_F0F0, B=32'h0FF0_0FF0, opcode 00, rsp0_ready=1:
  - req0_ready=1 in the same cycle
  - next cycle rsp0_valid=1, rsp_result=32'h00F0_00F0, rsp_err=0
  - rsp1_valid stays 0
- Both valid every cycle: req0 XOR 32'hFFFF_0000 ^ 32'h00FF_00FF, req1 OR 32'h1 | 32'h2, both response readies held high:
  - grants alternate 0,1,0,1 starting with INIT_PRIO=0
  - results alternate 32'hFF00_00FF and 32'h0000_0003, one per cycle
- Backpressure: rsp1_ready=0 while a req1 result is held, req0 valid:
  - req0_ready=0 and rsp_result stable for 3 cycles
  - raise rsp1_ready: drain and accept of req0 in the same cycle, and the req0 result appears the next cycle
- Opcode 11 from req1 with any operands:
  - rsp1_valid=1, rsp_result=32'h0, rsp_err=1
  - a following valid opcode clears rsp_err
- Reset mid-operation: slot FULL for req0 with rsp0_ready=0, assert rst_i for one cycle:
  - next cycle rsp0_valid=0
  - pointer back to 0, so with both valid the next grant is req0
- Single requester repeated: only req1 valid, 4 requests with rsp1_ready=1:
  - accepted in consecutive cycles with no idle bubbles
  - pointer ends at 0
